// File: rtl/hazard_tag_pipeline.sv
// rtl/hazard_tag_pipeline.sv - destination-tag pipeline with load-use/memory-wait hazard control (optional HAZ_STATS_EN counters)
module hazard_tag_pipeline #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  ex_flush,
    input  logic                  exm_mem_req,
    input  logic                  mem_ready,
    output logic                  stall_if_id,
    output logic                  bubble_id_ex,
    output logic                  freeze_pipe,
    output logic [REG_ADDR_W-1:0] idex_rd,
    output logic [REG_ADDR_W-1:0] exm_rd,
    output logic [REG_ADDR_W-1:0] mwb_rd,
    output logic                  idex_regwrite,
    output logic                  exm_regwrite,
    output logic                  mwb_regwrite,
    output logic                  idex_memread,
    output logic [1:0]            state
`ifdef HAZ_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] ldstall_cnt,
    output logic [STALL_CNT_W-1:0] mwait_cnt,
    output logic [STALL_CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_LDUSE = 2'b01;
    localparam logic [1:0] ST_MWAIT = 2'b10;

    logic rs1_hit;
    logic rs2_hit;
    logic ldhaz;
    logic mwait;
    logic flush_win;
    logic ldhaz_win;
    logic idex_load_bubble;

    always_comb begin
        rs1_hit          = id_use_rs1 && (id_rs1 == idex_rd);
        rs2_hit          = id_use_rs2 && (id_rs2 == idex_rd);
        ldhaz            = idex_memread && (idex_rd != '0) && id_valid && (rs1_hit || rs2_hit);
        mwait            = exm_mem_req && !mem_ready;
        flush_win        = ex_flush && !mwait;
        ldhaz_win        = ldhaz && !mwait && !ex_flush;
        idex_load_bubble = ex_flush || ldhaz || !id_valid;
    end

    // Gated by rst_n so a reset mid-wait drops the controls even while request inputs stay high
    assign freeze_pipe  = rst_n && mwait;
    assign stall_if_id  = rst_n && (mwait || ldhaz_win);
    assign bubble_id_ex = rst_n && (flush_win || ldhaz_win);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_rd       <= '0;
            idex_regwrite <= 1'b0;
            idex_memread  <= 1'b0;
            exm_rd        <= '0;
            exm_regwrite  <= 1'b0;
            mwb_rd        <= '0;
            mwb_regwrite  <= 1'b0;
            state         <= ST_RUN;
        end else if (mwait) begin
            mwb_rd        <= '0;
            mwb_regwrite  <= 1'b0;
            state         <= ST_MWAIT;
        end else begin
            mwb_rd        <= exm_rd;
            mwb_regwrite  <= exm_regwrite;
            exm_rd        <= idex_rd;
            exm_regwrite  <= idex_regwrite;
            if (idex_load_bubble) begin
                idex_rd       <= '0;
                idex_regwrite <= 1'b0;
                idex_memread  <= 1'b0;
            end else begin
                idex_rd       <= id_rd;
                idex_regwrite <= id_regwrite && (id_rd != '0);
                idex_memread  <= id_memread;
            end
            state <= ldhaz_win ? ST_LDUSE : ST_RUN;
        end
    end

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldstall_cnt <= '0;
            mwait_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            if (ldhaz_win && !(&ldstall_cnt)) ldstall_cnt <= ldstall_cnt + 1'b1;
            if (mwait && !(&mwait_cnt))       mwait_cnt   <= mwait_cnt + 1'b1;
            if (flush_win && !(&flush_cnt))   flush_cnt   <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_tag_pipeline.sv
// tb/tb_hazard_tag_pipeline.sv - directed scoreboard bench for hazard_tag_pipeline
module tb_hazard_tag_pipeline;

    typedef struct packed {
        logic [4:0] idex_rd;
        logic       idex_rw;
        logic       idex_mr;
        logic [4:0] exm_rd;
        logic       exm_rw;
        logic [4:0] mwb_rd;
        logic       mwb_rw;
        logic [1:0] st;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_regwrite, id_memread;
    logic       ex_flush, exm_mem_req, mem_ready;
    logic       stall_if_id, bubble_id_ex, freeze_pipe;
    logic [4:0] idex_rd, exm_rd, mwb_rd;
    logic       idex_regwrite, exm_regwrite, mwb_regwrite, idex_memread;
    logic [1:0] state;
`ifdef HAZ_STATS_EN
    logic [15:0] ldstall_cnt, mwait_cnt, flush_cnt;
`endif

    int    vectors     = 0;
    int    miscompares = 0;
    snap_t exp_q[$];

    hazard_tag_pipeline dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_flush(ex_flush), .exm_mem_req(exm_mem_req), .mem_ready(mem_ready),
        .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .freeze_pipe(freeze_pipe),
        .idex_rd(idex_rd), .exm_rd(exm_rd), .mwb_rd(mwb_rd),
        .idex_regwrite(idex_regwrite), .exm_regwrite(exm_regwrite), .mwb_regwrite(mwb_regwrite),
        .idex_memread(idex_memread), .state(state)
`ifdef HAZ_STATS_EN
        , .ldstall_cnt(ldstall_cnt), .mwait_cnt(mwait_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(int ird, int irw, int imr, int erd, int erw, int mrd, int mrw, int st);
        snap_t s;
        s.idex_rd = 5'(ird); s.idex_rw = 1'(irw); s.idex_mr = 1'(imr);
        s.exm_rd  = 5'(erd); s.exm_rw  = 1'(erw);
        s.mwb_rd  = 5'(mrd); s.mwb_rw  = 1'(mrw);
        s.st      = 2'(st);
        return s;
    endfunction

    function automatic snap_t obs();
        return {idex_rd, idex_regwrite, idex_memread, exm_rd, exm_regwrite, mwb_rd, mwb_regwrite, state};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic set_id(input int v, input int rs1, input int u1, input int rs2, input int u2,
                          input int rd, input int rw, input int mr);
        id_valid = 1'(v); id_rs1 = 5'(rs1); id_use_rs1 = 1'(u1);
        id_rs2 = 5'(rs2); id_use_rs2 = 1'(u2);
        id_rd = 5'(rd); id_regwrite = 1'(rw); id_memread = 1'(mr);
    endtask

    task automatic set_ctl(input int fl, input int req, input int rdy);
        ex_flush = 1'(fl); exm_mem_req = 1'(req); mem_ready = 1'(rdy);
    endtask

    // Called just after a negedge with inputs driven: checks controls, then the registered result
    task automatic step(input string tag, input int e_stall, input int e_bub, input int e_frz, input snap_t e);
        snap_t got;
        #1;
        chk({tag, ".ctl"}, {29'd0, stall_if_id, bubble_id_ex, freeze_pipe},
            {29'd0, 1'(e_stall), 1'(e_bub), 1'(e_frz)});
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = obs();
        chk({tag, ".tags"}, 32'(got), 32'(exp_q.pop_front()));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset.tags", 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        chk("reset.ctl", {29'd0, stall_if_id, bubble_id_ex, freeze_pipe}, 32'd0);
        rst_n = 1'b1;

        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        step("load_x5", 0, 0, 0, mk(5, 1, 1, 0, 0, 0, 0, 0));
        set_id(1, 5, 1, 0, 0, 7, 1, 0);
        step("ldhaz_rs1", 1, 1, 0, mk(0, 0, 0, 5, 1, 0, 0, 1));
        step("after_ldhaz", 0, 0, 0, mk(7, 1, 0, 0, 0, 5, 1, 0));

        set_id(1, 0, 0, 0, 0, 0, 1, 1);
        step("load_x0", 0, 0, 0, mk(0, 0, 1, 7, 1, 0, 0, 0));
        set_id(1, 0, 1, 0, 0, 3, 1, 0);
        step("use_x0", 0, 0, 0, mk(3, 1, 0, 0, 0, 7, 1, 0));

        set_id(1, 0, 0, 0, 0, 9, 1, 1);
        step("load_x9", 0, 0, 0, mk(9, 1, 1, 3, 1, 0, 0, 0));
        set_id(1, 0, 0, 9, 1, 4, 1, 0);
        set_ctl(1, 0, 0);
        step("flush_ldhaz", 0, 1, 0, mk(0, 0, 0, 9, 1, 3, 1, 0));

        set_id(1, 0, 0, 0, 0, 6, 1, 1);
        set_ctl(0, 1, 1);
        step("memreq_ready", 0, 0, 0, mk(6, 1, 1, 0, 0, 9, 1, 0));

        set_id(1, 6, 1, 0, 0, 8, 1, 0);
        set_ctl(1, 1, 0);
        step("mwait1_all", 1, 0, 1, mk(6, 1, 1, 0, 0, 0, 0, 2));
        step("mwait2", 1, 0, 1, mk(6, 1, 1, 0, 0, 0, 0, 2));
        step("mwait3", 1, 0, 1, mk(6, 1, 1, 0, 0, 0, 0, 2));
        set_id(0, 6, 1, 0, 0, 8, 1, 0);
        set_ctl(0, 1, 1);
        step("mwait_exit", 0, 0, 0, mk(0, 0, 0, 6, 1, 0, 0, 0));

        set_id(1, 0, 0, 0, 0, 2, 1, 1);
        set_ctl(0, 0, 0);
        step("load_x2", 0, 0, 0, mk(2, 1, 1, 0, 0, 6, 1, 0));
        set_id(1, 0, 0, 0, 0, 11, 1, 0);
        set_ctl(0, 1, 0);
        step("mwait_pre_rst", 1, 0, 1, mk(2, 1, 1, 0, 0, 0, 0, 2));

`ifdef HAZ_STATS_EN
        chk("cnt.ldstall", 32'(ldstall_cnt), 32'd1);
        chk("cnt.mwait", 32'(mwait_cnt), 32'd4);
        chk("cnt.flush", 32'(flush_cnt), 32'd1);
`endif

        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid.tags", 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        chk("rst_mid.ctl", {29'd0, stall_if_id, bubble_id_ex, freeze_pipe}, 32'd0);
`ifdef HAZ_STATS_EN
        chk("rst_mid.cnt", 32'(ldstall_cnt | mwait_cnt | flush_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        set_id(1, 0, 0, 0, 0, 1, 1, 1);
        set_ctl(0, 0, 0);
        step("post_rst", 0, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
